ram_loader: RTL and testbench

//  Bus-master engine on the initiator side of the 8KB system RAM port (addr/w_en/din/dout, 1-cycle registered read).

---
 rtl/ram_loader_pkg.sv | 23 ++
 rtl/ram_loader.sv | 132 +++++++++++++
 tb/tb_ram_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared state encoding and sizing for the RAM load/dump engine.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package ram_loader_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 14;
  localparam int RAM_BYTES  = 2**DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_loader.sv
// ram_loader: host-link bus master that streams bytes into (LOAD) or out of (DUMP) the system RAM port.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    remaining;
  logic                rd_pend;
  logic [DATA_W-1:0]   obuf;
  logic                is_write;
  logic                done_zero;

  logic                accept;
  logic                rd_issue;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign bus_req   = (state == GRANT) || (state == LOAD) || (state == DUMP);
  assign in_ready  = (state == LOAD) && bus_gnt;
  assign ram_w_en  = in_ready && in_valid;
  assign ram_din   = (state == LOAD) ? in_data : '0;
  assign ram_addr  = cur_addr;
  assign out_data  = obuf;
  assign done      = done_zero || (state == DONE);

  // A new read waits until the one-entry buffer has drained, so out_ready never reaches the RAM port.
  assign rd_issue  = (state == DUMP) && bus_gnt && !rd_pend && !out_valid &&
                     (remaining != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      obuf      <= '0;
      out_valid <= 1'b0;
      is_write  <= 1'b0;
      done_zero <= 1'b0;
    end else begin
      done_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            is_write  <= cmd_write;
            if (cmd_len == '0) begin
              done_zero <= 1'b1;
            end else begin
              state <= GRANT;
            end
          end
        end
        GRANT: begin
          if (bus_gnt) begin
            state <= is_write ? LOAD : DUMP;
          end
        end
        LOAD: begin
          if (ram_w_en) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DUMP: begin
          if (rd_issue) begin
            rd_pend   <= 1'b1;
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
          end
          // Read data is captured regardless of grant; the RAM already latched the address.
          if (rd_pend) begin
            obuf      <= ram_dout;
            out_valid <= 1'b1;
            rd_pend   <= 1'b0;
          end
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (remaining == '0) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized and directed checks of ram_loader against a byte-array reference RAM.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          bus_req;
  logic          bus_gnt = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_w_en;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done)
  );

  // System RAM with a registered read port.
  logic [DW-1:0] mem [RAM_BYTES];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  logic [DW-1:0] ref_mem [RAM_BYTES];
  bit            ref_written [RAM_BYTES];
  logic [DW-1:0] load_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc / 3) % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({pfx, "_in_ready"},  32'(in_ready),  0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_bus_req"},   32'(bus_req),   0);
    chk({pfx, "_ram_w_en"},  32'(ram_w_en),  0);
    chk({pfx, "_busy"},      32'(busy),      0);
    chk({pfx, "_done"},      32'(done),      0);
    chk({pfx, "_ram_addr"},  32'(ram_addr),  0);
    chk({pfx, "_ram_din"},   32'(ram_din),   0);
    chk({pfx, "_out_data"},  32'(out_data),  0);
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'(len != 0));
  endtask

  task automatic ram_check(input string tag);
    int bad = 0;
    for (int i = 0; i < RAM_BYTES; i++)
      if (ref_written[i] && mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic do_load(input int addr, input int len, input int gmode, input bit consec);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    bit fin = 0;
    send_cmd(1'b1, addr, len);
    while (!fin && cyc < 1000) begin
      bus_gnt  = gnt_pat(gmode, cyc);
      in_valid = (idx < len);
      in_data  = (idx < len) ? load_q[idx] : 8'h00;
      #1;
      if (done) begin
        fin = 1;
        chk("load_count", idx, len);
        chk("load_bus_req_done", 32'(bus_req), 0);
      end else begin
        chk("load_bus_req", 32'(bus_req), 1);
        chk("load_wen_needs_gnt", 32'(ram_w_en & ~bus_gnt), 0);
        if (first >= 0) chk("in_ready_tracks_gnt", 32'(in_ready), 32'(bus_gnt));
        if (in_valid && in_ready) begin
          chk("load_wen", 32'(ram_w_en), 1);
          chk("load_addr", 32'(ram_addr), (addr + idx) % RAM_BYTES);
          chk("load_din", 32'(ram_din), 32'(load_q[idx]));
          if (first < 0) first = cyc;
          last = cyc;
          idx++;
        end else begin
          chk("load_no_wen", 32'(ram_w_en), 0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (!fin) chk("load_timeout", 0, 1);
    if (consec) chk("load_consecutive", last - first, len - 1);
    chk("load_done_one_cycle", 32'(done), 0);
    chk("load_idle_after", 32'(busy), 0);
    for (int i = 0; i < len; i++) begin
      ref_mem[(addr + i) % RAM_BYTES]     = load_q[i];
      ref_written[(addr + i) % RAM_BYTES] = 1'b1;
    end
  endtask

  task automatic do_dump(input int addr, input int len, input int gmode, input int rmode,
                         input int stall);
    int idx = 0;
    int cyc = 0;
    int stalled = 0;
    bit fin = 0;
    logic [DW-1:0] hold_d = '0;
    logic [AW-1:0] hold_a = '0;
    send_cmd(1'b0, addr, len);
    while (!fin && cyc < 2000) begin
      bus_gnt = gnt_pat(gmode, cyc);
      if (out_valid && stalled < stall) out_ready = 1'b0;
      else out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (done) begin
        fin = 1;
        chk("dump_count", idx, len);
        chk("dump_read_count", 32'(ram_addr), (addr + len) % RAM_BYTES);
      end else begin
        chk("dump_no_wen", 32'(ram_w_en), 0);
        if (out_valid && stalled < stall) begin
          if (stalled == 0) begin
            hold_d = out_data;
            hold_a = ram_addr;
          end else begin
            chk("stall_data_stable", 32'(out_data), 32'(hold_d));
            chk("stall_no_read", 32'(ram_addr), 32'(hold_a));
          end
          stalled++;
        end
        if (out_valid && out_ready) begin
          chk("dump_data", 32'(out_data), 32'(ref_mem[(addr + idx) % RAM_BYTES]));
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (!fin) chk("dump_timeout", 0, 1);
    chk("dump_done_one_cycle", 32'(done), 0);
    chk("dump_idle_after", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed LOAD of A1..A4 with continuous grant.
    load_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_load(32'h0100, 4, 0, 1'b1);
    ram_check("ram_after_load1");

    // Preload across the top of RAM, then dump it back to check wrap.
    load_q = '{8'h5A, 8'hC3, 8'h96, 8'h3C};
    do_load(32'h1FFE, 4, 0, 1'b1);
    ram_check("ram_after_wrap_load");
    do_dump(32'h1FFE, 4, 0, 0, 0);

    // Consumer stall of 10 cycles.
    do_dump(32'h0100, 3, 0, 0, 10);

    // Grant toggled every 3 clocks.
    load_q.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(8'($urandom));
    do_load(32'h0200, 8, 1, 1'b0);
    ram_check("ram_after_gnt_toggle");
    do_dump(32'h0200, 8, 1, 1, 0);

    // Zero-length commands of both kinds.
    for (int w = 0; w < 2; w++) begin
      bus_gnt = 1'b1;
      send_cmd(1'(w), 32'h0040, 0);
      #1;
      chk("len0_done", 32'(done), 1);
      chk("len0_no_req", 32'(bus_req), 0);
      @(negedge clk);
      chk("len0_done_clear", 32'(done), 0);
      chk("len0_no_req2", 32'(bus_req), 0);
      chk("len0_idle", 32'(busy), 0);
    end

    // Randomized load/dump pairs with random grant and consumer.
    for (int t = 0; t < 6; t++) begin
      int a;
      int n;
      a = $urandom_range(0, RAM_BYTES - 1);
      n = $urandom_range(1, 12);
      load_q.delete();
      for (int i = 0; i < n; i++) load_q.push_back(8'($urandom));
      do_load(a, n, 2, 1'b0);
      do_dump(a, n, 2, 1, 0);
    end
    ram_check("ram_after_random");

    // Reset in the middle of a DUMP.
    bus_gnt   = 1'b1;
    out_ready = 1'b0;
    send_cmd(1'b0, 32'h0100, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    do_dump(32'h0100, 4, 0, 0, 0);
    ram_check("ram_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
